// File: rtl/rename_dispatch_pkg.sv
// Shared definitions for the rename/dispatch stage: architectural register
// count, instruction field positions and the old-mapping queue entry layout.
package rename_dispatch_pkg;

    localparam int NUM_ARCH_REGS  = 32;
    localparam int ARCH_W         = 5;
    localparam int RD_LSB         = 7;
    localparam int RS1_LSB        = 15;
    localparam int RS2_LSB        = 20;
    localparam int PREG_W_DEFAULT = 6;

    typedef logic [ARCH_W-1:0]         areg_t;
    typedef logic [PREG_W_DEFAULT-1:0] preg_t;

    // One entry per dispatched instruction, retired in program order at commit.
    typedef struct packed {
        logic  wr;
        preg_t old_prd;
    } old_map_t;

    // Extract a 5-bit architectural register field starting at bit lsb.
    function automatic areg_t arch_field(input logic [31:0] inst, input int lsb);
        return inst[lsb +: ARCH_W];
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with full/empty flags; push when full and pop when
// empty are ignored. Read data is the current head, valid while not empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rename_dispatch_free_list.sv
// Circular free list of physical registers. Reset loads it full with the
// registers above the architectural range, in ascending order from the head.
module preg_free_list
    import rename_dispatch_pkg::*;
#(
    parameter int NUM_PREGS = 64,
    parameter int PREG_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [PREG_W-1:0] push_preg,
    input  logic              pop,
    output logic [PREG_W-1:0] head,
    output logic [PREG_W:0]   count
);

    localparam int DEPTH = NUM_PREGS - NUM_ARCH_REGS;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PREG_W-1:0] mem [DEPTH];
    logic [PREG_W-1:0] head_ptr;
    logic [PREG_W-1:0] tail_ptr;

    // Pointers are full register-address width but wrap at the list depth.
    function automatic logic [PREG_W-1:0] next_ptr(input logic [PREG_W-1:0] ptr);
        return (ptr == PREG_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign head = mem[head_ptr[IDX_W-1:0]];

    // Reset reload of the list plus push/pop of registers and pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PREG_W'(NUM_ARCH_REGS + i);
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= (PREG_W+1)'(DEPTH);
        end else begin
            if (push) begin
                mem[tail_ptr[IDX_W-1:0]] <= push_preg;
                tail_ptr <= next_ptr(tail_ptr);
            end
            if (pop) head_ptr <= next_ptr(head_ptr);
            count <= count + (PREG_W+1)'(push) - (PREG_W+1)'(pop);
        end
    end

endmodule

// File: rtl/rename_dispatch.sv
// Rename/dispatch stage: maps rs1/rs2/rd through the register alias table,
// allocates new destinations from the free list, and returns superseded
// physical registers to the free list when the ROB commits in order.
module rename_dispatch
    import rename_dispatch_pkg::*;
#(
    parameter int NUM_PREGS = 64,
    parameter int PREG_W    = 6,
    parameter int ROB_DEPTH = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              inst_valid_i,
    input  logic [31:0]       inst_i,
    input  logic [31:0]       pc_i,
    input  logic              rd_wen_i,
    output logic              inst_ready_o,
    input  logic              rob_full_i,
    output logic              allocate_req_o,
    output logic [PREG_W-1:0] prd_addr_o,
    output logic [PREG_W-1:0] prs1_addr_o,
    output logic [PREG_W-1:0] prs2_addr_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    input  logic              commit_valid_i,
    output logic [PREG_W:0]   free_cnt_o
);

    logic [PREG_W-1:0] rat [NUM_ARCH_REGS];

    areg_t             rd;
    areg_t             rs1;
    areg_t             rs2;
    logic              wr;
    logic              fire;
    logic [PREG_W-1:0] old_prd;
    logic [PREG_W-1:0] fl_head;
    logic              fl_push;
    logic              fl_pop;
    logic              oldq_full;
    logic              oldq_empty;
    logic              oldq_pop;
    logic [PREG_W:0]   oldq_wdata;
    logic [PREG_W:0]   oldq_rdata;

    assign rd  = arch_field(inst_i, RD_LSB);
    assign rs1 = arch_field(inst_i, RS1_LSB);
    assign rs2 = arch_field(inst_i, RS2_LSB);

    // Writes to x0 are not renamed and never consume a free register.
    assign wr   = rd_wen_i && (rd != '0);
    assign inst_ready_o = !reset_i && !rob_full_i && !oldq_full &&
                          (!wr || (free_cnt_o != '0));
    assign fire = inst_valid_i && inst_ready_o;
    assign allocate_req_o = fire;

    assign pc_o   = pc_i;
    assign inst_o = inst_i;

    // Lookups read the pre-update table, so rs==rd sees the old mapping.
    assign prs1_addr_o = (rs1 == '0) ? '0 : rat[rs1];
    assign prs2_addr_o = (rs2 == '0) ? '0 : rat[rs2];
    assign old_prd     = (rd == '0) ? '0 : rat[rd];
    assign prd_addr_o  = wr ? fl_head : old_prd;

    // Every dispatched instruction records its superseded mapping.
    assign oldq_wdata = {wr, old_prd};
    assign oldq_pop   = commit_valid_i && !oldq_empty;
    assign fl_push    = oldq_pop && oldq_rdata[PREG_W];
    assign fl_pop     = fire && wr;

    // Alias table: identity at reset, renamed destination on each writing fire.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                rat[i] <= PREG_W'(i);
            end
        end else if (fl_pop) begin
            rat[rd] <= fl_head;
        end
    end

    preg_free_list #(
        .NUM_PREGS (NUM_PREGS),
        .PREG_W    (PREG_W)
    ) u_free_list (
        .clk       (clk_i),
        .reset     (reset_i),
        .push      (fl_push),
        .push_preg (oldq_rdata[PREG_W-1:0]),
        .pop       (fl_pop),
        .head      (fl_head),
        .count     (free_cnt_o)
    );

    fifo #(
        .WIDTH (PREG_W + 1),
        .DEPTH (ROB_DEPTH)
    ) u_old_map_q (
        .clk   (clk_i),
        .reset (reset_i),
        .push  (fire),
        .wdata (oldq_wdata),
        .pop   (oldq_pop),
        .rdata (oldq_rdata),
        .full  (oldq_full),
        .empty (oldq_empty)
    );

endmodule

// File: tb/tb_rename_dispatch.sv
// Directed bench for rename_dispatch: rename, allocation, x0 handling, free
// list exhaustion, in-order reclamation, same-cycle alloc/free, stalls, reset.
module tb_rename_dispatch;

    localparam int NP = 64;
    localparam int PW = 6;
    localparam int RD = 40;

    logic          clk;
    logic          reset_i;
    logic          inst_valid_i;
    logic [31:0]   inst_i;
    logic [31:0]   pc_i;
    logic          rd_wen_i;
    logic          inst_ready_o;
    logic          rob_full_i;
    logic          allocate_req_o;
    logic [PW-1:0] prd_addr_o;
    logic [PW-1:0] prs1_addr_o;
    logic [PW-1:0] prs2_addr_o;
    logic [31:0]   pc_o;
    logic [31:0]   inst_o;
    logic          commit_valid_i;
    logic [PW:0]   free_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    rename_dispatch #(
        .NUM_PREGS (NP),
        .PREG_W    (PW),
        .ROB_DEPTH (RD)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .inst_valid_i   (inst_valid_i),
        .inst_i         (inst_i),
        .pc_i           (pc_i),
        .rd_wen_i       (rd_wen_i),
        .inst_ready_o   (inst_ready_o),
        .rob_full_i     (rob_full_i),
        .allocate_req_o (allocate_req_o),
        .prd_addr_o     (prd_addr_o),
        .prs1_addr_o    (prs1_addr_o),
        .prs2_addr_o    (prs2_addr_o),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .commit_valid_i (commit_valid_i),
        .free_cnt_o     (free_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
        logic [4:0] f_rd;
        logic [4:0] f_rs1;
        logic [4:0] f_rs2;
        f_rd  = rd[4:0];
        f_rs1 = rs1[4:0];
        f_rs2 = rs2[4:0];
        return {7'h00, f_rs2, f_rs1, 3'b000, f_rd, 7'h33};
    endfunction

    task automatic drive(input logic v, input int rd, input int rs1, input int rs2, input logic wen);
        inst_valid_i = v;
        inst_i       = mk(rd, rs1, rs2);
        rd_wen_i     = wen;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        reset_i        = 1'b1;
        inst_valid_i   = 1'b0;
        inst_i         = '0;
        pc_i           = 32'h0000_1000;
        rd_wen_i       = 1'b0;
        rob_full_i     = 1'b0;
        commit_valid_i = 1'b0;

        // Reset: nothing accepted while reset is held.
        drive(1, 5, 5, 0, 1);
        chk("rst_ready", inst_ready_o, 0);
        chk("rst_alloc", allocate_req_o, 0);
        tick();
        tick();
        reset_i = 1'b0;
        drive(0, 0, 7, 31, 0);
        chk("rst_free_cnt", free_cnt_o, 32);
        chk("rst_rat_rs1", prs1_addr_o, 7);
        chk("rst_rat_rs2", prs2_addr_o, 31);

        // First rename: rd=5 rs1=5 rs2=0.
        pc_i = 32'h0000_2468;
        drive(1, 5, 5, 0, 1);
        chk("t1_ready", inst_ready_o, 1);
        chk("t1_alloc", allocate_req_o, 1);
        chk("t1_prd", prd_addr_o, 32);
        chk("t1_prs1", prs1_addr_o, 5);
        chk("t1_prs2", prs2_addr_o, 0);
        chk("t1_pc", pc_o, 32'h0000_2468);
        chk("t1_inst", inst_o, 32'h0002_82B3);
        tick();
        drive(1, 6, 5, 6, 1);
        chk("t1b_prs1", prs1_addr_o, 32);
        chk("t1b_prs2", prs2_addr_o, 6);
        chk("t1b_prd", prd_addr_o, 33);
        chk("t1b_free", free_cnt_o, 31);
        tick();
        chk("t1c_free", free_cnt_o, 30);

        // Write to x0 is not renamed.
        drive(1, 0, 5, 0, 1);
        chk("x0_alloc", allocate_req_o, 1);
        chk("x0_prd", prd_addr_o, 0);
        chk("x0_prs1", prs1_addr_o, 32);
        tick();
        chk("x0_free", free_cnt_o, 30);

        // Drain: p5, p6 come back, the x0 entry returns nothing.
        drive(0, 0, 0, 0, 0);
        commit_valid_i = 1'b1;
        tick();
        chk("cm1_free", free_cnt_o, 31);
        tick();
        chk("cm2_free", free_cnt_o, 32);
        tick();
        chk("cm3_x0_free", free_cnt_o, 32);
        tick();
        chk("cm_empty_free", free_cnt_o, 32);
        commit_valid_i = 1'b0;

        // Fresh start: write x3 twice, commit twice, reclaim order.
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        drive(1, 3, 0, 0, 1);
        chk("x3a_prd", prd_addr_o, 32);
        tick();
        drive(1, 3, 3, 0, 1);
        chk("x3b_prs1", prs1_addr_o, 32);
        chk("x3b_prd", prd_addr_o, 33);
        tick();
        chk("x3_free30", free_cnt_o, 30);
        drive(0, 0, 0, 0, 0);
        commit_valid_i = 1'b1;
        tick();
        chk("x3_free31", free_cnt_o, 31);
        tick();
        chk("x3_free32", free_cnt_o, 32);
        commit_valid_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive(1, (i % 31) + 1, 0, 0, 1);
            chk($sformatf("x3_alloc%0d", i), prd_addr_o, 34 + i);
            tick();
        end
        drive(1, 7, 0, 0, 1);
        chk("x3_reuse_p3", prd_addr_o, 3);
        tick();
        drive(1, 8, 0, 0, 1);
        chk("x3_reuse_p32", prd_addr_o, 32);
        tick();
        chk("x3_free0", free_cnt_o, 0);

        // Fresh start: exhaust the free list.
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1, (i % 31) + 1, 0, 0, 1);
            chk($sformatf("ex_alloc%0d", i), prd_addr_o, 32 + i);
            tick();
        end
        chk("ex_free0", free_cnt_o, 0);
        drive(1, 9, 0, 0, 1);
        chk("ex_writer_ready", inst_ready_o, 0);
        chk("ex_writer_alloc", allocate_req_o, 0);
        drive(1, 0, 0, 0, 1);
        chk("ex_x0_ready", inst_ready_o, 1);
        chk("ex_x0_prd", prd_addr_o, 0);
        tick();
        drive(1, 4, 0, 0, 0);
        chk("ex_nw_ready", inst_ready_o, 1);
        chk("ex_nw_prd", prd_addr_o, 35);
        tick();
        for (int i = 0; i < 6; i++) tick();
        chk("oq_full_ready", inst_ready_o, 0);
        chk("oq_full_alloc", allocate_req_o, 0);
        chk("oq_full_free", free_cnt_o, 0);

        // Commit the oldest entry (x1 <- p1 superseded): one register frees up.
        drive(0, 0, 0, 0, 0);
        commit_valid_i = 1'b1;
        tick();
        commit_valid_i = 1'b0;
        chk("cm_p1_free", free_cnt_o, 1);

        // Same cycle allocate and free with a single free register.
        drive(1, 10, 0, 0, 1);
        commit_valid_i = 1'b1;
        #1;
        chk("same_ready", inst_ready_o, 1);
        chk("same_prd", prd_addr_o, 1);
        chk("same_free_pre", free_cnt_o, 1);
        tick();
        commit_valid_i = 1'b0;
        chk("same_free_post", free_cnt_o, 1);
        drive(1, 11, 10, 0, 1);
        chk("same_next_prd", prd_addr_o, 2);
        chk("same_rat10", prs1_addr_o, 1);
        tick();
        chk("same_free0", free_cnt_o, 0);

        // ROB full blocks dispatch and leaves the table alone.
        rob_full_i = 1'b1;
        drive(1, 12, 10, 0, 0);
        chk("rf_ready", inst_ready_o, 0);
        chk("rf_alloc", allocate_req_o, 0);
        chk("rf_prs1", prs1_addr_o, 1);
        tick();
        rob_full_i = 1'b0;
        drive(0, 0, 12, 11, 0);
        chk("rf_rat12", prs1_addr_o, 43);
        chk("rf_rat11", prs2_addr_o, 2);
        chk("rf_free", free_cnt_o, 0);

        // Reset in the middle of the stream discards everything.
        reset_i = 1'b1;
        drive(1, 12, 0, 0, 1);
        chk("mid_rst_ready", inst_ready_o, 0);
        chk("mid_rst_alloc", allocate_req_o, 0);
        tick();
        reset_i = 1'b0;
        drive(0, 0, 12, 11, 0);
        chk("mid_rat12", prs1_addr_o, 12);
        chk("mid_rat11", prs2_addr_o, 11);
        chk("mid_free", free_cnt_o, 32);
        commit_valid_i = 1'b1;
        tick();
        commit_valid_i = 1'b0;
        chk("mid_empty_commit", free_cnt_o, 32);
        drive(1, 12, 12, 0, 1);
        chk("mid_prd", prd_addr_o, 32);
        chk("mid_prs1", prs1_addr_o, 12);
        tick();
        drive(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
